// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants and field helpers for the multiplier and adder datapaths.
package bf16_pkg;

   localparam int BF16_W = 16;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 7;
   localparam int BIAS   = 127;

   localparam logic [EXP_W-1:0]  EXP_MAX = 8'hFF;
   localparam logic [BF16_W-1:0] QNAN    = 16'h7FC0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } bf16_t;

   function automatic bf16_t bf16_unpack(input logic [BF16_W-1:0] v);
      return bf16_t'(v);
   endfunction

endpackage

// File: rtl/bf16_mul_norm.sv
// Combinational tail of the multiplier: normalise the mantissa product, clamp the
// exponent and pack special-class results.
module bf16_mul_norm
   import bf16_pkg::*;
(
   input  logic                      sign,
   input  logic signed [EXP_W+1:0]   esum,
   input  logic [2*FRAC_W+1:0]       mprod,
   input  logic                      is_nan,
   input  logic                      is_inf,
   input  logic                      is_zero,
   output logic [BF16_W-1:0]         result
);

   localparam int ESUM_W  = EXP_W + 2;
   localparam int MPROD_W = 2 * FRAC_W + 2;
   localparam logic signed [ESUM_W-1:0] E_OVF = ESUM_W'(255);
   localparam logic signed [ESUM_W-1:0] E_ONE = ESUM_W'(1);

   logic signed [ESUM_W-1:0] e_norm;
   logic [FRAC_W-1:0]        frac;

   // Product of two [1,2) mantissas lies in [1,4); the top bit decides the shift.
   always_comb begin
      e_norm = esum;
      frac   = mprod[MPROD_W-3 -: FRAC_W];
      if (mprod[MPROD_W-1]) begin
         e_norm = esum + E_ONE;
         frac   = mprod[MPROD_W-2 -: FRAC_W];
      end
   end

   always_comb begin
      result = {sign, {(BF16_W-1){1'b0}}};
      if (is_nan) begin
         result = QNAN;
      end else if (is_inf) begin
         result = {sign, EXP_MAX, {FRAC_W{1'b0}}};
      end else if (is_zero) begin
         result = {sign, {(BF16_W-1){1'b0}}};
      end else if (e_norm >= E_OVF) begin
         result = {sign, EXP_MAX, {FRAC_W{1'b0}}};
      end else if (e_norm <= $signed({ESUM_W{1'b0}})) begin
         result = {sign, {(BF16_W-1){1'b0}}};
      end else begin
         result = {sign, e_norm[EXP_W-1:0], frac};
      end
   end

endmodule

// File: rtl/bf16_mul_pipe.sv
// Two-stage bfloat16 multiplier with valid/ready handshake; truncating rounding,
// denormals flushed to zero, fully stallable from the output side.
module bf16_mul_pipe #(
   parameter int EXP_W  = bf16_pkg::EXP_W,
   parameter int FRAC_W = bf16_pkg::FRAC_W,
   parameter int BIAS   = bf16_pkg::BIAS
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [EXP_W+FRAC_W:0]     a,
   input  logic [EXP_W+FRAC_W:0]     b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [EXP_W+FRAC_W:0]     product
);

   localparam int ESUM_W  = EXP_W + 2;
   localparam int MANT_W  = FRAC_W + 1;
   localparam int MPROD_W = 2 * MANT_W;
   localparam logic signed [ESUM_W-1:0] BIAS_S = ESUM_W'(BIAS);

   bf16_pkg::bf16_t ua, ub;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic nan_next, inf_next, zero_next;
   logic signed [ESUM_W-1:0] esum_next;
   logic [MPROD_W-1:0]       mprod_next;

   logic                     s1_valid_reg, s2_valid_reg;
   logic                     s1_sign_reg, s1_nan_reg, s1_inf_reg, s1_zero_reg;
   logic signed [ESUM_W-1:0] s1_esum_reg;
   logic [MPROD_W-1:0]       s1_mprod_reg;
   logic [EXP_W+FRAC_W:0]    product_reg;
   logic [EXP_W+FRAC_W:0]    norm_result;
   logic                     s1_adv, s2_adv;

   assign s2_adv    = !s2_valid_reg || out_ready;
   assign s1_adv    = !s1_valid_reg || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_reg;
   assign product   = product_reg;

   always_comb begin
      ua         = bf16_pkg::bf16_unpack(a);
      ub         = bf16_pkg::bf16_unpack(b);
      a_zero     = (ua.exp == '0);
      b_zero     = (ub.exp == '0);
      a_inf      = (ua.exp == bf16_pkg::EXP_MAX) && (ua.frac == '0);
      b_inf      = (ub.exp == bf16_pkg::EXP_MAX) && (ub.frac == '0);
      a_nan      = (ua.exp == bf16_pkg::EXP_MAX) && (ua.frac != '0);
      b_nan      = (ub.exp == bf16_pkg::EXP_MAX) && (ub.frac != '0);
      // Inf x zero is folded into the NaN flag so the pack stage sees one priority chain.
      nan_next   = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
      inf_next   = a_inf || b_inf;
      zero_next  = a_zero || b_zero;
      esum_next  = $signed({2'b00, ua.exp}) + $signed({2'b00, ub.exp}) - BIAS_S;
      mprod_next = MPROD_W'({1'b1, ua.frac}) * MPROD_W'({1'b1, ub.frac});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_sign_reg  <= 1'b0;
         s1_nan_reg   <= 1'b0;
         s1_inf_reg   <= 1'b0;
         s1_zero_reg  <= 1'b0;
         s1_esum_reg  <= '0;
         s1_mprod_reg <= '0;
      end else if (s1_adv) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_sign_reg  <= ua.sign ^ ub.sign;
            s1_nan_reg   <= nan_next;
            s1_inf_reg   <= inf_next;
            s1_zero_reg  <= zero_next;
            s1_esum_reg  <= esum_next;
            s1_mprod_reg <= mprod_next;
         end
      end
   end

   bf16_mul_norm u_norm (
      .sign    (s1_sign_reg),
      .esum    (s1_esum_reg),
      .mprod   (s1_mprod_reg),
      .is_nan  (s1_nan_reg),
      .is_inf  (s1_inf_reg),
      .is_zero (s1_zero_reg),
      .result  (norm_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         product_reg  <= '0;
      end else if (s2_adv) begin
         s2_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            product_reg <= norm_result;
         end
      end
   end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// Scoreboard bench for bf16_mul_pipe: directed arithmetic, latency, backpressure,
// random streaming against a reference model, and mid-stream reset.
module tb_bf16_mul_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] product;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] sb_q[$];

   bf16_mul_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
      logic s, xn, yn, xi, yi, xz, yz;
      int   ex, ey, e, m;
      s  = x[15] ^ y[15];
      ex = int'(x[14:7]);
      ey = int'(y[14:7]);
      xn = (ex == 255) && (x[6:0] != 7'h0);
      yn = (ey == 255) && (y[6:0] != 7'h0);
      xi = (ex == 255) && (x[6:0] == 7'h0);
      yi = (ey == 255) && (y[6:0] == 7'h0);
      xz = (ex == 0);
      yz = (ey == 0);
      if (xn || yn) return 16'h7FC0;
      if ((xi && yz) || (yi && xz)) return 16'h7FC0;
      if (xi || yi) return {s, 8'hFF, 7'h00};
      if (xz || yz) return {s, 15'h0000};
      m = (128 + int'(x[6:0])) * (128 + int'(y[6:0]));
      e = ex + ey - 127;
      if (m >= 32768) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 7'h00};
      if (e <= 0) return {s, 15'h0000};
      return {s, e[7:0], m[13:7]};
   endfunction

   function automatic logic [15:0] rnd_op();
      logic [15:0] specials[8];
      specials = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC1, 16'h0001, 16'h7F7F, 16'h0080};
      if ($urandom_range(0, 7) == 0) return specials[$urandom_range(0, 7)];
      return 16'($urandom());
   endfunction

   // One clock of stimulus; pops/compares the scoreboard on every output transfer.
   task automatic step(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic [15:0] exp_v, input logic ordy, output logic acc);
      logic [15:0] want;
      in_valid  = v;
      a         = av;
      b         = bv;
      out_ready = ordy;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_extra product=%h expected no output", product);
         end else begin
            want = sb_q.pop_front();
            $display("txn product=%h expected=%h", product, want);
            if (product !== want) begin
               failures++;
               $display("FAIL sb_product product=%h expected=%h", product, want);
            end
         end
      end
      if (acc) sb_q.push_back(exp_v);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(output int left);
      logic acc;
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, acc);
      left = sb_q.size();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || product !== 16'h0000 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state out_valid=%b product=%h in_ready=%b expected 0/0000/1",
                  out_valid, product, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_latency(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] exp_v);
      logic acc;
      int   left;
      step(1'b1, av, bv, exp_v, 1'b1, acc);
      checks++;
      if (acc !== 1'b1) begin
         failures++;
         $display("FAIL latency_accept accepted=%b expected 1", acc);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL latency_early out_valid=%b expected 0 one cycle after accept", out_valid);
      end
      step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, acc);
      checks++;
      if (out_valid !== 1'b1 || product !== exp_v) begin
         failures++;
         $display("FAIL latency_two out_valid=%b product=%h expected 1/%h", out_valid, product, exp_v);
      end
      drain(left);
      checks++;
      if (left != 0) begin
         failures++;
         $display("FAIL latency_drain pending=%0d expected 0", left);
      end
   endtask

   task automatic test_arith();
      logic [15:0] ta[8], tbv[8], te[8];
      logic        acc;
      int          left;
      ta  = '{16'h3FC0, 16'hC000, 16'h8000, 16'h7F00, 16'h0080, 16'h7F80, 16'h7FC1, 16'h0000};
      tbv = '{16'h3FC0, 16'h4040, 16'h4040, 16'h7F00, 16'h0080, 16'h0000, 16'h3F80, 16'hFF80};
      te  = '{16'h4010, 16'hC0C0, 16'h8000, 16'h7F80, 16'h0000, 16'h7FC0, 16'h7FC0, 16'h7FC0};
      for (int i = 0; i < 8; i++) begin
         step(1'b1, ta[i], tbv[i], te[i], 1'b1, acc);
         checks++;
         if (acc !== 1'b1) begin
            failures++;
            $display("FAIL arith_accept idx=%0d accepted=%b expected 1", i, acc);
         end
      end
      drain(left);
      checks++;
      if (left != 0) begin
         failures++;
         $display("FAIL arith_drain pending=%0d expected 0", left);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] pa[4], pb[4], pe[4];
      logic        acc;
      int          idx, left;
      pa = '{16'h3F80, 16'h4040, 16'hC000, 16'h3FC0};
      pb = '{16'h4000, 16'h4040, 16'h3F80, 16'h4000};
      pe = '{16'h4000, 16'h4110, 16'hC000, 16'h4040};
      step(1'b1, pa[0], pb[0], pe[0], 1'b0, acc);
      step(1'b1, pa[1], pb[1], pe[1], 1'b0, acc);
      checks++;
      if (acc !== 1'b1) begin
         failures++;
         $display("FAIL bp_second_accept accepted=%b expected 1", acc);
      end
      for (int c = 0; c < 2; c++) begin
         checks++;
         if (out_valid !== 1'b1 || product !== pe[0]) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d out_valid=%b product=%h expected 1/%h", c, out_valid, product, pe[0]);
         end
         step(1'b1, pa[2], pb[2], pe[2], 1'b0, acc);
         checks++;
         if (acc !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready cycle=%0d accepted=%b expected 0 with both stages full", c, acc);
         end
      end
      checks++;
      if (product !== pe[0]) begin
         failures++;
         $display("FAIL bp_stable product=%h expected %h", product, pe[0]);
      end
      idx = 2;
      for (int c = 0; c < 20 && idx < 4; c++) begin
         step(1'b1, pa[idx], pb[idx], pe[idx], 1'b1, acc);
         if (acc) idx++;
      end
      drain(left);
      checks++;
      if (idx != 4 || left != 0) begin
         failures++;
         $display("FAIL bp_complete accepted=%0d pending=%0d expected 4/0", idx, left);
      end
   endtask

   task automatic test_random();
      logic [15:0] av, bv;
      logic        acc, v;
      int          n, left;
      n = 0;
      for (int c = 0; c < 20000 && n < 1000; c++) begin
         v  = ($urandom_range(0, 3) != 0);
         av = rnd_op();
         bv = rnd_op();
         step(v, av, bv, ref_mul(av, bv), 1'($urandom_range(0, 1)), acc);
         if (acc) n++;
      end
      drain(left);
      checks++;
      if (n != 1000 || left != 0) begin
         failures++;
         $display("FAIL random_complete accepted=%0d pending=%0d expected 1000/0", n, left);
      end
   endtask

   task automatic test_reset_mid();
      logic acc;
      step(1'b1, 16'h3F80, 16'h4000, 16'h4000, 1'b0, acc);
      step(1'b1, 16'h4040, 16'h4040, 16'h4110, 1'b0, acc);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_full out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || product !== 16'h0000) begin
         failures++;
         $display("FAIL rst_mid_clear out_valid=%b product=%h expected 0/0000", out_valid, product);
      end
      sb_q.delete();
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_latency(16'h4000, 16'h4000, 16'h4080);
   endtask

   initial begin
      test_reset();
      test_latency(16'h3F80, 16'h3F80, 16'h3F80);
      test_arith();
      test_backpressure();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
